channel_ccw: RTL and testbench

- Parametrised successor to the single-command parallel channel (bus-and-tag) sequencer.
- Executes one CCW-style operation: selection, command, initial status, data transfer bounded by a byte count, then ending status.
- Adds configurable tag timing, a byte count with residual, count-exhausted stop, short-busy and no-device detection, and a tag-response timeout.
- Sits between the host/CCW fetch logic and the Parallel Channel "A" bus-and-tag pins.

---
 rtl/channel_ccw.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_channel_ccw.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_ccw.sv
// Parallel channel "A" bus-and-tag sequencer: runs one CCW (selection, command,
// initial status, count-bounded data transfer, ending status) and reports residual/errors.
module channel_ccw #(
  parameter int COUNT_WIDTH         = 16,
  parameter int ADDR_SETUP_CYCLES   = 3,
  parameter int SELECT_DELAY_CYCLES = 4,
  parameter int TIMEOUT_CYCLES      = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             a_bus_in,
  output logic [7:0]             a_bus_out,
  output logic                   a_operational_out,
  output logic                   a_hold_out,
  output logic                   a_select_out,
  output logic                   a_address_out,
  output logic                   a_command_out,
  output logic                   a_service_out,
  output logic                   a_suppress_out,
  input  logic                   a_operational_in,
  input  logic                   a_select_in,
  input  logic                   a_address_in,
  input  logic                   a_status_in,
  input  logic                   a_service_in,
  input  logic                   a_request_in,
  input  logic [7:0]             address,
  input  logic [7:0]             command,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic                   start,
  input  logic                   stop,
  output logic                   active,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] residual,
  output logic                   err_short_busy,
  output logic                   err_no_device,
  output logic                   err_timeout,
  output logic                   err_length,
  output logic [7:0]             status_tdata,
  output logic                   status_tvalid,
  input  logic [7:0]             data_send_tdata,
  input  logic                   data_send_tvalid,
  output logic                   data_send_tready,
  output logic [7:0]             data_recv_tdata,
  output logic                   data_recv_tvalid,
  input  logic                   data_recv_tready
);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_ADDR_OUT, S_SELECT, S_ADDR_IN, S_CMD, S_INIT_STATUS,
    S_ACK_INIT, S_XFER, S_SVC_WAIT, S_STOP_WAIT, S_ACK_END, S_DISC
  } state_t;

  // Outbound tag vector {hold, select, address, command, service}; error vector {sb, nd, to, len}
  localparam int T_HOLD = 4, T_SEL = 3, T_ADR = 2, T_CMD = 1, T_SVC = 0;
  localparam int E_SB = 3, E_ND = 2, E_TO = 1, E_LEN = 0;
  // Device End is IBM bit 5 of the status byte (bit 0 = MSB)
  localparam logic [7:0] DE_MASK = 8'h04;
  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

  state_t                 r_state, w_state_nxt;
  logic [31:0]            r_phase, r_tmo;
  logic [4:0]             r_tag_q, r_tags, w_tags_nxt, w_tag_in;
  logic [7:0]             r_addr, w_addr_nxt, r_cmd, w_cmd_nxt, r_status, w_status_nxt;
  logic [7:0]             r_bus_out, w_bus_nxt, r_sts_tdata, w_sts_tdata_nxt;
  logic [7:0]             r_recv_tdata, w_recv_tdata_nxt;
  logic [COUNT_WIDTH-1:0] r_residual, w_residual_nxt;
  logic [3:0]             r_err, w_err_nxt;
  logic                   r_opl, r_done, r_active, r_sts_tvalid, w_sts_tvalid_nxt;
  logic                   r_send_tready, w_send_tready_nxt, r_recv_tvalid, w_recv_tvalid_nxt;
  logic                   r_short_busy, w_short_busy_nxt, r_stop_req, w_stop_req_nxt;
  logic                   w_edge, w_timeout, w_wait_state, w_send_hs, w_recv_hs, w_to_idle;
  logic                   w_unused;

  assign w_unused   = a_request_in;
  assign w_tag_in   = {a_operational_in, a_select_in, a_address_in, a_status_in, a_service_in};
  assign w_edge     = |(w_tag_in ^ r_tag_q);
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_tmo + 32'd1 >= 32'(TIMEOUT_CYCLES));
  assign w_send_hs  = r_send_tready && data_send_tvalid;
  assign w_recv_hs  = r_recv_tvalid && data_recv_tready;
  assign w_wait_state = (r_state != S_IDLE) && (r_state != S_SETUP) && (r_state != S_ADDR_OUT);

  always_comb begin
    w_state_nxt       = r_state;
    w_tags_nxt        = r_tags;
    w_bus_nxt         = r_bus_out;
    w_addr_nxt        = r_addr;
    w_cmd_nxt         = r_cmd;
    w_status_nxt      = r_status;
    w_residual_nxt    = r_residual;
    w_err_nxt         = r_err;
    w_sts_tdata_nxt   = r_sts_tdata;
    w_sts_tvalid_nxt  = 1'b0;
    w_send_tready_nxt = r_send_tready;
    w_recv_tdata_nxt  = r_recv_tdata;
    w_recv_tvalid_nxt = r_recv_tvalid;
    w_short_busy_nxt  = r_short_busy;
    w_stop_req_nxt    = r_stop_req;
    w_to_idle         = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_addr_nxt       = address;
        w_cmd_nxt        = command;
        w_residual_nxt   = count;
        w_err_nxt        = '0;
        w_short_busy_nxt = 1'b0;
        w_stop_req_nxt   = 1'b0;
        w_bus_nxt        = address;
        w_state_nxt      = S_SETUP;
      end
      S_SETUP: if (r_phase + 32'd1 >= 32'(ADDR_SETUP_CYCLES)) begin
        w_tags_nxt[T_ADR] = 1'b1;
        w_state_nxt       = S_ADDR_OUT;
      end
      S_ADDR_OUT: if (r_phase + 32'd1 >= 32'(SELECT_DELAY_CYCLES)) begin
        w_tags_nxt[T_SEL]  = 1'b1;
        w_tags_nxt[T_HOLD] = 1'b1;
        w_state_nxt        = S_SELECT;
      end
      S_SELECT: begin
        if (a_operational_in) begin
          w_tags_nxt[T_ADR] = 1'b0;
          w_state_nxt       = S_ADDR_IN;
        end else if (a_status_in) begin
          w_sts_tdata_nxt   = a_bus_in;
          w_sts_tvalid_nxt  = 1'b1;
          w_status_nxt      = a_bus_in;
          w_err_nxt[E_SB]   = 1'b1;
          w_short_busy_nxt  = 1'b1;
          w_tags_nxt        = 5'b00001;
          w_state_nxt       = S_ACK_END;
        end else if (a_select_in) begin
          w_err_nxt[E_ND]   = 1'b1;
          w_state_nxt       = S_IDLE;
        end
      end
      S_ADDR_IN: if (a_address_in) begin
        w_tags_nxt[T_CMD] = 1'b1;
        if (a_bus_in == r_addr) begin
          w_bus_nxt   = r_cmd;
          w_state_nxt = S_CMD;
        end else begin
          w_err_nxt[E_ND] = 1'b1;
          w_bus_nxt       = 8'h00;
          w_state_nxt     = S_DISC;
        end
      end
      S_CMD: if (!a_address_in) begin
        w_tags_nxt[T_CMD] = 1'b0;
        w_bus_nxt         = 8'h00;
        w_state_nxt       = S_INIT_STATUS;
      end
      S_INIT_STATUS: if (a_status_in) begin
        w_sts_tdata_nxt   = a_bus_in;
        w_sts_tvalid_nxt  = 1'b1;
        w_status_nxt      = a_bus_in;
        w_tags_nxt[T_SVC] = 1'b1;
        w_state_nxt       = S_ACK_INIT;
      end
      S_ACK_INIT: if (!a_status_in) begin
        w_tags_nxt[T_SVC] = 1'b0;
        w_state_nxt = (r_status == 8'h00 && r_cmd != 8'h00) ? S_XFER : S_IDLE;
      end
      S_XFER: begin
        // A handshake already taken on the stream must complete before a stop is honoured
        if (a_service_in) begin
          if (w_send_hs || w_recv_hs) begin
            w_send_tready_nxt = 1'b0;
            w_recv_tvalid_nxt = 1'b0;
            if (w_send_hs) w_bus_nxt = data_send_tdata;
            if (r_residual != '0) w_residual_nxt = r_residual - ONE;
            w_tags_nxt[T_SVC] = 1'b1;
            w_state_nxt       = S_SVC_WAIT;
          end else if (r_residual == '0 || stop) begin
            w_send_tready_nxt = 1'b0;
            w_recv_tvalid_nxt = 1'b0;
            if (stop) w_stop_req_nxt = 1'b1;
            if (r_residual == '0) w_err_nxt[E_LEN] = 1'b1;
            w_tags_nxt[T_CMD] = 1'b1;
            w_state_nxt       = S_STOP_WAIT;
          end else if (r_cmd[0]) begin
            w_send_tready_nxt = 1'b1;
          end else begin
            w_recv_tdata_nxt  = a_bus_in;
            w_recv_tvalid_nxt = 1'b1;
          end
        end else if (a_status_in) begin
          w_sts_tdata_nxt   = a_bus_in;
          w_sts_tvalid_nxt  = 1'b1;
          w_status_nxt      = a_bus_in;
          w_send_tready_nxt = 1'b0;
          w_recv_tvalid_nxt = 1'b0;
          if (r_residual != '0 && !r_stop_req && !stop) w_err_nxt[E_LEN] = 1'b1;
          w_tags_nxt[T_SVC] = 1'b1;
          w_state_nxt       = S_ACK_END;
        end else begin
          w_send_tready_nxt = 1'b0;
          w_recv_tvalid_nxt = 1'b0;
        end
      end
      S_SVC_WAIT, S_STOP_WAIT: if (!a_service_in) begin
        w_tags_nxt[T_SVC] = 1'b0;
        w_tags_nxt[T_CMD] = 1'b0;
        w_state_nxt       = S_XFER;
      end
      S_ACK_END: if (!a_status_in) begin
        w_tags_nxt[T_SVC] = 1'b0;
        w_state_nxt = ((r_status & DE_MASK) != 8'h00 || r_short_busy) ? S_IDLE : S_XFER;
      end
      S_DISC: if (!a_operational_in) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_timeout && w_wait_state && w_state_nxt == r_state) begin
      w_err_nxt[E_TO] = 1'b1;
      w_state_nxt     = S_IDLE;
    end
    w_to_idle = (r_state != S_IDLE) && (w_state_nxt == S_IDLE);
    if (w_to_idle) begin
      w_tags_nxt        = '0;
      w_bus_nxt         = 8'h00;
      w_send_tready_nxt = 1'b0;
      w_recv_tvalid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_phase       <= '0;
      r_tmo         <= '0;
      r_tag_q       <= '0;
      r_tags        <= '0;
      r_bus_out     <= '0;
      r_opl         <= 1'b1;
      r_addr        <= '0;
      r_cmd         <= '0;
      r_status      <= '0;
      r_residual    <= '0;
      r_err         <= '0;
      r_sts_tdata   <= '0;
      r_sts_tvalid  <= 1'b0;
      r_send_tready <= 1'b0;
      r_recv_tdata  <= '0;
      r_recv_tvalid <= 1'b0;
      r_short_busy  <= 1'b0;
      r_stop_req    <= 1'b0;
      r_done        <= 1'b0;
      r_active      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_phase       <= (w_state_nxt != r_state) ? '0 : r_phase + 32'd1;
      r_tmo         <= (w_state_nxt != r_state || w_edge) ? '0 : r_tmo + 32'd1;
      r_tag_q       <= w_tag_in;
      r_tags        <= w_tags_nxt;
      r_bus_out     <= w_bus_nxt;
      r_opl         <= 1'b1;
      r_addr        <= w_addr_nxt;
      r_cmd         <= w_cmd_nxt;
      r_status      <= w_status_nxt;
      r_residual    <= w_residual_nxt;
      r_err         <= w_err_nxt;
      r_sts_tdata   <= w_sts_tdata_nxt;
      r_sts_tvalid  <= w_sts_tvalid_nxt;
      r_send_tready <= w_send_tready_nxt;
      r_recv_tdata  <= w_recv_tdata_nxt;
      r_recv_tvalid <= w_recv_tvalid_nxt;
      r_short_busy  <= w_short_busy_nxt;
      r_stop_req    <= w_stop_req_nxt;
      r_done        <= w_to_idle;
      r_active      <= (w_state_nxt != S_IDLE);
    end
  end

  assign a_bus_out         = r_bus_out;
  assign a_operational_out = r_opl;
  assign a_hold_out        = r_tags[T_HOLD];
  assign a_select_out      = r_tags[T_SEL];
  assign a_address_out     = r_tags[T_ADR];
  assign a_command_out     = r_tags[T_CMD];
  assign a_service_out     = r_tags[T_SVC];
  assign a_suppress_out    = 1'b0;
  assign active            = r_active;
  assign done              = r_done;
  assign residual          = r_residual;
  assign err_short_busy    = r_err[E_SB];
  assign err_no_device     = r_err[E_ND];
  assign err_timeout       = r_err[E_TO];
  assign err_length        = r_err[E_LEN];
  assign status_tdata      = r_sts_tdata;
  assign status_tvalid     = r_sts_tvalid;
  assign data_send_tready  = r_send_tready;
  assign data_recv_tdata   = r_recv_tdata;
  assign data_recv_tvalid  = r_recv_tvalid;

endmodule

// File: tb/tb_channel_ccw.sv
// Directed bench for channel_ccw: table of whole-CCW scenarios driven by a simple
// device model, plus hand-written short-busy, no-device, timeout and reset sequences.
module tb_channel_ccw;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  a_bus_in, a_bus_out;
  logic        a_operational_out, a_hold_out, a_select_out, a_address_out;
  logic        a_command_out, a_service_out, a_suppress_out;
  logic        a_operational_in, a_select_in, a_address_in, a_status_in, a_service_in, a_request_in;
  logic [7:0]  address, command;
  logic [15:0] count, residual;
  logic        start, stop, active, done;
  logic        err_short_busy, err_no_device, err_timeout, err_length;
  logic [7:0]  status_tdata, data_send_tdata, data_recv_tdata;
  logic        status_tvalid, data_send_tvalid, data_send_tready, data_recv_tvalid, data_recv_tready;

  channel_ccw #(.COUNT_WIDTH(16), .ADDR_SETUP_CYCLES(3), .SELECT_DELAY_CYCLES(4),
                .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .a_bus_in(a_bus_in), .a_bus_out(a_bus_out),
    .a_operational_out(a_operational_out), .a_hold_out(a_hold_out),
    .a_select_out(a_select_out), .a_address_out(a_address_out),
    .a_command_out(a_command_out), .a_service_out(a_service_out),
    .a_suppress_out(a_suppress_out), .a_operational_in(a_operational_in),
    .a_select_in(a_select_in), .a_address_in(a_address_in), .a_status_in(a_status_in),
    .a_service_in(a_service_in), .a_request_in(a_request_in), .address(address),
    .command(command), .count(count), .start(start), .stop(stop), .active(active),
    .done(done), .residual(residual), .err_short_busy(err_short_busy),
    .err_no_device(err_no_device), .err_timeout(err_timeout), .err_length(err_length),
    .status_tdata(status_tdata), .status_tvalid(status_tvalid),
    .data_send_tdata(data_send_tdata), .data_send_tvalid(data_send_tvalid),
    .data_send_tready(data_send_tready), .data_recv_tdata(data_recv_tdata),
    .data_recv_tvalid(data_recv_tvalid), .data_recv_tready(data_recv_tready));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr, cmd, reply, init_sts, end_sts, b0, b1, b2;
    logic [15:0] cnt, exp_res;
    int          nsvc;
    logic [3:0]  exp_err;   // {short_busy, no_device, timeout, length}
  } vec_t;

  localparam int W_SEL = 0, W_ADR = 1, W_CMD = 2, W_SVC = 3, W_DONE = 4;

  int n_tests = 0, n_fail = 0, done_cnt = 0;
  vec_t tbl [7];

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      W_SEL:   return a_select_out;
      W_ADR:   return a_address_out;
      W_CMD:   return a_command_out;
      W_SVC:   return a_service_out;
      default: return done;
    endcase
  endfunction

  task automatic wait_sig(input int w, input logic v, input string nm);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (sig(w) === v) seen = 1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: wait timed out, signal %0d never reached %0b", nm, w, v);
    end
  endtask

  function automatic logic [7:0] pick(input vec_t v, input int k);
    case (k)
      0:       return v.b0;
      1:       return v.b1;
      default: return v.b2;
    endcase
  endfunction

  task automatic dev_idle();
    a_bus_in = 8'h00; a_operational_in = 0; a_select_in = 0; a_address_in = 0;
    a_status_in = 0; a_service_in = 0; data_send_tvalid = 0; data_send_tdata = 8'h00;
  endtask

  task automatic host_start(input vec_t v);
    @(negedge clk);
    address = v.addr; command = v.cmd; count = v.cnt; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  // Start through address-in; leaves the channel raising command_out
  task automatic do_select(input vec_t v, input string t);
    host_start(v);
    wait_sig(W_SEL, 1, {t, "_sel"});
    check({t, "_sel_bus"}, a_bus_out, v.addr);
    a_operational_in = 1;
    wait_sig(W_ADR, 0, {t, "_adr_drop"});
    a_bus_in = v.reply; a_address_in = 1;
    wait_sig(W_CMD, 1, {t, "_cmd_rise"});
  endtask

  task automatic do_cmd_init(input vec_t v, input string t);
    check({t, "_cmd_bus"}, a_bus_out, v.cmd);
    a_address_in = 0; a_bus_in = 8'h00;
    wait_sig(W_CMD, 0, {t, "_cmd_drop"});
    a_bus_in = v.init_sts; a_status_in = 1;
    wait_sig(W_SVC, 1, {t, "_init_ack"});
    check({t, "_init_sts"}, {status_tvalid, status_tdata}, {1'b1, v.init_sts});
    a_status_in = 0; a_bus_in = 8'h00;
  endtask

  task automatic run_op(input vec_t v, input string t);
    int base = done_cnt;
    logic [7:0] got;
    bit resp;
    do_select(v, t);
    if (v.reply != v.addr) begin
      check({t, "_disc_bus"}, a_bus_out, 8'h00);
      a_address_in = 0; a_operational_in = 0; a_bus_in = 8'h00;
      wait_sig(W_DONE, 1, {t, "_done"});
    end else begin
      do_cmd_init(v, t);
      if (v.init_sts == 8'h00 && v.cmd != 8'h00) begin
        wait_sig(W_SVC, 0, {t, "_init_end"});
        for (int k = 0; k < v.nsvc; k++) begin
          got = 8'h00; resp = 0;
          a_bus_in = pick(v, k); a_service_in = 1;
          data_send_tdata = pick(v, k); data_send_tvalid = v.cmd[0];
          for (int c = 0; c < 40 && !resp; c++) begin
            @(negedge clk);
            if (a_service_out || a_command_out) resp = 1;
            else if (data_recv_tvalid && data_recv_tready) got = data_recv_tdata;
          end
          check($sformatf("%s_resp%0d", t, k), {a_service_out, a_command_out},
                (k < int'(v.cnt)) ? 2'b10 : 2'b01);
          if (k < int'(v.cnt) && v.cmd[0]) check($sformatf("%s_wr%0d", t, k), a_bus_out, pick(v, k));
          if (k < int'(v.cnt) && !v.cmd[0]) check($sformatf("%s_rd%0d", t, k), got, pick(v, k));
          data_send_tvalid = 0; a_service_in = 0; a_bus_in = 8'h00;
          wait_sig((k < int'(v.cnt)) ? W_SVC : W_CMD, 0, {t, "_svc_end"});
        end
        a_bus_in = v.end_sts; a_status_in = 1;
        wait_sig(W_SVC, 1, {t, "_end_ack"});
        check({t, "_end_sts"}, {status_tvalid, status_tdata}, {1'b1, v.end_sts});
        a_status_in = 0; a_bus_in = 8'h00;
        wait_sig(W_SVC, 0, {t, "_end_drop"});
      end
      a_operational_in = 0;
      if (!done) wait_sig(W_DONE, 1, {t, "_done"});
    end
    check({t, "_residual"}, residual, v.exp_res);
    check({t, "_errs"}, {err_short_busy, err_no_device, err_timeout, err_length}, v.exp_err);
    check({t, "_tags_idle"}, {active, a_hold_out, a_select_out, a_address_out, a_command_out, a_service_out}, 6'b0);
    dev_idle();
    repeat (3) @(negedge clk);
    check({t, "_one_done"}, done_cnt - base, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int base, c;
    bit cmd_seen;
    reset = 0; start = 0; stop = 0; a_request_in = 0; data_recv_tready = 1;
    address = 8'h00; command = 8'h00; count = 16'h0;
    dev_idle();
    repeat (3) @(negedge clk);
    check("rst_tags", {a_hold_out, a_select_out, a_address_out, a_command_out, a_service_out, a_suppress_out}, 6'b0);
    check("rst_opl", a_operational_out, 1'b1);
    check("rst_ctl", {active, done, status_tvalid, data_send_tready, data_recv_tvalid, a_bus_out}, 13'b0);
    check("rst_res_err", {residual, err_short_busy, err_no_device, err_timeout, err_length}, 20'b0);
    reset = 1;

    tbl[0] = '{addr:8'h40, cmd:8'h01, reply:8'h40, init_sts:8'h00, end_sts:8'h0C, b0:8'hAA, b1:8'hBB, b2:8'hCC, cnt:16'd3, exp_res:16'd0, nsvc:3, exp_err:4'b0000};
    tbl[1] = '{addr:8'h40, cmd:8'h02, reply:8'h40, init_sts:8'h00, end_sts:8'h0C, b0:8'h11, b1:8'h22, b2:8'h33, cnt:16'd2, exp_res:16'd0, nsvc:3, exp_err:4'b0001};
    tbl[2] = '{addr:8'h40, cmd:8'h01, reply:8'h40, init_sts:8'h00, end_sts:8'h0C, b0:8'h5A, b1:8'hA5, b2:8'h00, cnt:16'd5, exp_res:16'd3, nsvc:2, exp_err:4'b0001};
    tbl[3] = '{addr:8'h22, cmd:8'h00, reply:8'h22, init_sts:8'h00, end_sts:8'h00, b0:8'h00, b1:8'h00, b2:8'h00, cnt:16'd7, exp_res:16'd7, nsvc:0, exp_err:4'b0000};
    tbl[4] = '{addr:8'h40, cmd:8'h02, reply:8'h40, init_sts:8'h02, end_sts:8'h00, b0:8'h00, b1:8'h00, b2:8'h00, cnt:16'd4, exp_res:16'd4, nsvc:0, exp_err:4'b0000};
    tbl[5] = '{addr:8'h7F, cmd:8'h01, reply:8'h41, init_sts:8'h00, end_sts:8'h00, b0:8'h00, b1:8'h00, b2:8'h00, cnt:16'd4, exp_res:16'd4, nsvc:0, exp_err:4'b0100};
    tbl[6] = '{addr:8'h40, cmd:8'h01, reply:8'h40, init_sts:8'h00, end_sts:8'h0C, b0:8'h99, b1:8'h00, b2:8'h00, cnt:16'd0, exp_res:16'd0, nsvc:1, exp_err:4'b0001};

    for (int i = 0; i < 7; i++) run_op(tbl[i], $sformatf("v%0d", i));

    // Short busy: status_in answers selection
    v = tbl[0];
    base = done_cnt;
    host_start(v);
    wait_sig(W_SEL, 1, "sb_sel");
    a_bus_in = 8'h10; a_status_in = 1;
    wait_sig(W_SVC, 1, "sb_ack");
    check("sb_sts", {status_tvalid, status_tdata}, {1'b1, 8'h10});
    check("sb_flag", err_short_busy, 1'b1);
    check("sb_sel_drop", {a_select_out, a_hold_out, a_address_out}, 3'b0);
    repeat (2) @(negedge clk);
    check("sb_svc_held", a_service_out, 1'b1);
    a_status_in = 0; a_bus_in = 8'h00;
    wait_sig(W_DONE, 1, "sb_done");
    check("sb_errs", {err_short_busy, err_no_device, err_timeout, err_length}, 4'b1000);
    check("sb_tags", {active, a_service_out, a_select_out, a_hold_out}, 4'b0);
    repeat (3) @(negedge clk);
    check("sb_one_done", done_cnt - base, 1);

    // No device: select_in returns with no operational_in
    base = done_cnt;
    host_start(v);
    wait_sig(W_SEL, 1, "nd_sel");
    a_select_in = 1;
    c = 0; cmd_seen = 0;
    do begin
      @(negedge clk);
      c++;
      if (a_command_out) cmd_seen = 1;
    end while (active && c < 10);
    check("nd_latency_ok", (c <= 2), 1'b1);
    check("nd_no_cmd", cmd_seen, 1'b0);
    check("nd_errs", {err_short_busy, err_no_device, err_timeout, err_length}, 4'b0100);
    a_select_in = 0;
    repeat (3) @(negedge clk);
    check("nd_one_done", done_cnt - base, 1);

    // Timeout: device never raises address_in
    base = done_cnt;
    host_start(v);
    wait_sig(W_SEL, 1, "to_sel");
    a_operational_in = 1;
    wait_sig(W_ADR, 0, "to_adr_drop");
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!err_timeout && c < 60);
    check("to_cycle", c, 20);
    check("to_tags", {active, a_hold_out, a_select_out, a_address_out, a_command_out, a_service_out}, 6'b0);
    check("to_opl", a_operational_out, 1'b1);
    check("to_errs", {err_short_busy, err_no_device, err_timeout, err_length}, 4'b0010);
    a_operational_in = 0;
    repeat (3) @(negedge clk);
    check("to_one_done", done_cnt - base, 1);

    // Asynchronous reset while the channel holds service_out in SVC_WAIT
    v = tbl[0];
    do_select(v, "rs");
    do_cmd_init(v, "rs");
    wait_sig(W_SVC, 0, "rs_init_end");
    data_send_tdata = 8'h77; data_send_tvalid = 1; a_service_in = 1;
    wait_sig(W_SVC, 1, "rs_svc");
    base = done_cnt;
    #2 reset = 0;
    #1;
    check("rs_tags", {active, a_hold_out, a_select_out, a_address_out, a_command_out, a_service_out}, 6'b0);
    check("rs_bus_opl", {a_bus_out, a_operational_out}, {8'h00, 1'b1});
    dev_idle();
    repeat (3) @(negedge clk);
    reset = 1;
    repeat (3) @(negedge clk);
    check("rs_no_done", done_cnt - base, 0);
    run_op(tbl[0], "rs_again");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
